multicycle_seq: RTL

Multi-cycle sequencer for the RV32I core. It shares a single memory port between instruction fetch and data access. It walks each instruction through FETCH/DECODE/EXEC/MEM/WB and emits the datapath strobes and selects that the single-cycle decoder drives combinationally. It sits between the IR/PC registers, the ALU/branch comparator, the register file and the unified memory port.

---
 rtl/rv_ctrl_pkg.sv | 46 ++++
 rtl/inst_classify.sv | 26 ++
 rtl/multicycle_seq.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared control definitions for the RV32I multi-cycle sequencer:
// opcodes, sequencer states, instruction classes and select encodings.
package rv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_IALU,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_JALR,
    CLS_ILL
  } cls_t;

  typedef enum logic [1:0] {
    PC_JAL    = 2'b00,
    PC_JALR   = 2'b01,
    PC_PLUS4  = 2'b10,
    PC_BRANCH = 2'b11
  } pc_sel_t;

  typedef enum logic [1:0] {
    WB_MEM = 2'b00,
    WB_ALU = 2'b01,
    WB_PC4 = 2'b10
  } wb_sel_t;

endpackage

// File: rtl/inst_classify.sv
// Combinational opcode-to-class decoder; unknown opcodes map to CLS_ILL.
module inst_classify
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] cls
);

  cls_t cls_dec;

  always_comb begin
    case (opcode)
      OP_R:      cls_dec = CLS_R;
      OP_IALU:   cls_dec = CLS_IALU;
      OP_LOAD:   cls_dec = CLS_LOAD;
      OP_STORE:  cls_dec = CLS_STORE;
      OP_BRANCH: cls_dec = CLS_BRANCH;
      OP_JALR:   cls_dec = CLS_JALR;
      OP_JAL:    cls_dec = CLS_JAL;
      default:   cls_dec = CLS_ILL;
    endcase
  end

  assign cls = cls_dec;

endmodule

// File: rtl/multicycle_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer sharing one memory port
// between instruction fetch and data access, with memory-wait timeout.
module multicycle_seq
  import rv_ctrl_pkg::*;
#(
  parameter logic [31:0] HALT_PC     = 32'hFFFF_FFFC,
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic [6:0]  inst_opcode,
  input  logic        br_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_wen,
  output logic        pc_wen,
  output logic [1:0]  pc_sel,
  output logic        op1_sel,
  output logic        op2_sel,
  output logic        rf_wen,
  output logic [1:0]  wb_sel,
  output logic        retire,
  output logic [2:0]  state,
  output logic        halted,
  output logic        illegal,
  output logic        timeout
);

  state_t           state_q, state_d;
  cls_t             cls_dec, cls_q;
  logic [2:0]       cls_raw;
  logic [CNT_W-1:0] wait_cnt;
  logic             wait_expired;

  inst_classify u_classify (
    .opcode (inst_opcode),
    .cls    (cls_raw)
  );

  assign cls_dec      = cls_t'(cls_raw);
  assign state        = state_q;
  assign wait_expired = mem_req && !mem_ready && (wait_cnt == CNT_W'(TIMEOUT_CYC));

  always_ff @(posedge clk) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: begin
        if (pc == HALT_PC)   state_d = HALT;
        else if (mem_ready)  state_d = DECODE;
        else if (wait_expired) state_d = HALT;
      end
      DECODE: state_d = (cls_dec == CLS_ILL) ? HALT : EXEC;
      EXEC: begin
        case (cls_q)
          CLS_BRANCH:          state_d = FETCH;
          CLS_LOAD, CLS_STORE: state_d = MEM;
          default:             state_d = WB;
        endcase
      end
      MEM: begin
        if (mem_ready)         state_d = (cls_q == CLS_STORE) ? FETCH : WB;
        else if (wait_expired) state_d = HALT;
      end
      WB:      state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_wen       = 1'b0;
    pc_wen       = 1'b0;
    pc_sel       = PC_JAL;
    op1_sel      = 1'b0;
    op2_sel      = 1'b0;
    rf_wen       = 1'b0;
    wb_sel       = WB_MEM;
    case (state_q)
      FETCH: begin
        if (pc != HALT_PC) begin
          mem_req = 1'b1;
          ir_wen  = mem_ready;
        end
      end
      EXEC: begin
        case (cls_q)
          CLS_IALU, CLS_LOAD, CLS_STORE, CLS_JALR: op2_sel = 1'b1;
          CLS_JAL: begin
            op1_sel = 1'b1;
            op2_sel = 1'b1;
          end
          default: ;
        endcase
        if (cls_q == CLS_BRANCH) begin
          pc_wen = 1'b1;
          pc_sel = br_taken ? PC_BRANCH : PC_PLUS4;
        end
      end
      MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (cls_q == CLS_STORE);
        if (mem_ready && cls_q == CLS_STORE) begin
          pc_wen = 1'b1;
          pc_sel = PC_PLUS4;
        end
      end
      WB: begin
        rf_wen = 1'b1;
        pc_wen = 1'b1;
        case (cls_q)
          CLS_LOAD: begin
            wb_sel = WB_MEM;
            pc_sel = PC_PLUS4;
          end
          CLS_JAL: begin
            wb_sel = WB_PC4;
            pc_sel = PC_JAL;
          end
          CLS_JALR: begin
            wb_sel = WB_PC4;
            pc_sel = PC_JALR;
          end
          default: begin
            wb_sel = WB_ALU;
            pc_sel = PC_PLUS4;
          end
        endcase
      end
      default: ;
    endcase
    // Outputs decode the old state during the reset cycle; squash them so an
    // aborted instruction cannot leak a strobe.
    if (reset) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_wen       = 1'b0;
      pc_wen       = 1'b0;
      pc_sel       = PC_JAL;
      op1_sel      = 1'b0;
      op2_sel      = 1'b0;
      rf_wen       = 1'b0;
      wb_sel       = WB_MEM;
    end
  end

  assign retire = pc_wen;

  always_ff @(posedge clk) begin
    if (reset) begin
      cls_q    <= CLS_R;
      wait_cnt <= '0;
      halted   <= 1'b0;
      illegal  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      if (state_q == DECODE) cls_q <= cls_dec;
      if (state_d != state_q || mem_ready) wait_cnt <= '0;
      else if (mem_req)                    wait_cnt <= wait_cnt + CNT_W'(1);
      if (state_d == HALT) halted <= 1'b1;
      if (state_q == DECODE && cls_dec == CLS_ILL) illegal <= 1'b1;
      if (wait_expired) timeout <= 1'b1;
    end
  end

endmodule
